// File: rtl/bram_sdp_be.sv
// Single-clock simple dual-port RAM with byte-lane write enables, selectable read-during-write
// behaviour, optional output register and read-valid strobe. Only the read path is reset.
module bram_sdp_be #(
  parameter int    DEPTH          = 512,
  parameter int    ADDR_WIDTH     = 9,
  parameter int    DATA_WIDTH     = 32,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    OUT_REG        = 0,
  parameter string RDW_MODE       = "WRITE_FIRST",
  parameter string RAM_STYLE_ATTR = "block"
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rvalid
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_chk_width
    $fatal(1, "bram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (64'(DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_chk_depth
    $fatal(1, "bram_sdp_be: DEPTH exceeds 2**ADDR_WIDTH");
  end
  if ((RDW_MODE != "WRITE_FIRST") && (RDW_MODE != "READ_FIRST")) begin : g_chk_rdw
    $fatal(1, "bram_sdp_be: RDW_MODE must be WRITE_FIRST or READ_FIRST");
  end
  if (RAM_STYLE_ATTR == "") begin : g_chk_style
    $fatal(1, "bram_sdp_be: RAM_STYLE_ATTR must not be empty");
  end

  (* ram_style = RAM_STYLE_ATTR *)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  hit_s;
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd1_q;
  logic                  hit_q;
  logic [NUM_BYTES-1:0]  hit_be_q;
  logic [DATA_WIDTH-1:0] hit_data_q;
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] s1_data_s;

  assign wr_ok_s = we && ({1'b0, waddr} < DEPTH_W);
  assign rd_ok_s = {1'b0, raddr} < DEPTH_W;
  assign hit_s   = wr_ok_s && re && (raddr == waddr);

  // Storage write, byte lanes gated individually; ignored while in reset
  always_ff @(posedge clk) begin
    if (resetn && wr_ok_s) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wbe[i]) begin
          mem_q[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Array read value; out-of-range addresses read as zero
  always_comb begin
    rd1_d = '0;
    if (rd_ok_s) begin
      rd1_d = mem_q[raddr];
    end else begin
      rd1_d = '0;
    end
  end

  // Stage-1 read register with the collision context captured alongside it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd1_q      <= '0;
      hit_q      <= 1'b0;
      hit_be_q   <= '0;
      hit_data_q <= '0;
      v1_q       <= 1'b0;
    end else begin
      v1_q <= re;
      if (re) begin
        rd1_q      <= rd1_d;
        hit_q      <= hit_s;
        hit_be_q   <= wbe;
        hit_data_q <= wdata;
      end
    end
  end

  // Write-first collisions overlay the written lanes on the pre-write word read from the array
  always_comb begin
    s1_data_s = rd1_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      s1_data_s[i*BYTE_WIDTH +: BYTE_WIDTH] = (WRITE_FIRST && hit_q && hit_be_q[i]) ?
          hit_data_q[i*BYTE_WIDTH +: BYTE_WIDTH] : rd1_q[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd2_q;
    logic                  v2_q;

    // Output register advances only on a valid stage-1 result so rdata holds between reads
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd2_q <= '0;
        v2_q  <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          rd2_q <= s1_data_s;
        end
      end
    end

    assign rdata  = rd2_q;
    assign rvalid = v2_q;
  end else begin : g_no_out_reg
    assign rdata  = s1_data_s;
    assign rvalid = v1_q;
  end

endmodule

// File: tb/tb_bram_sdp_be.sv
// Scoreboard bench: two instances (WRITE_FIRST/latency 1/DEPTH 512 and READ_FIRST/latency 2/DEPTH 300)
// share one stimulus stream and are each checked against an array model.
module tb_bram_sdp_be;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [3:0]  wbe;
  logic [8:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [8:0]  raddr;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] mem_a [512];
  logic [31:0] mem_b [300];
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;

  bram_sdp_be #(.DEPTH(512), .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(0),
                .RDW_MODE("WRITE_FIRST"), .RAM_STYLE_ATTR("block")) dut_a (
    .clk(clk), .resetn(resetn), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

  bram_sdp_be #(.DEPTH(300), .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(1),
                .RDW_MODE("READ_FIRST"), .RAM_STYLE_ATTR("distributed")) dut_b (
    .clk(clk), .resetn(resetn), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    end
    return r;
  endfunction

  // One cycle of stimulus; the model applies write-first or read-first ordering per instance
  task automatic step(input bit w, input logic [3:0] be, input int wa, input logic [31:0] wd,
                      input bit r, input int ra);
    exp_t e;
    we = w; wbe = be; waddr = 9'(wa); wdata = wd; re = r; raddr = 9'(ra);
    if (w && wa < 512) mem_a[wa] = merge(mem_a[wa], wd, be);
    if (r) begin
      e.d = (ra < 512) ? mem_a[ra] : 32'h0; e.c = cyc; qa.push_back(e);
      e.d = (ra < 300) ? mem_b[ra] : 32'h0; e.c = cyc; qb.push_back(e);
    end
    if (w && wa < 300) mem_b[wa] = merge(mem_b[wa], wd, be);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, be, a, d, 1'b0, 0);
  endtask

  task automatic rd(input int a);
    step(1'b0, 4'h0, 0, 32'h0, 1'b1, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; we = 1'b0; re = 1'b0;
    qa.delete(); qb.delete();
    #1;
    chk("async_rst_rvalid_a", {31'h0, rvalid_a}, 32'h0);
    chk("async_rst_rdata_a", rdata_a, 32'h0);
    chk("async_rst_rvalid_b", {31'h0, rvalid_b}, 32'h0);
    chk("async_rst_rdata_b", rdata_b, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor A: pops on rvalid, checks data and latency, otherwise checks rdata holds
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!resetn) begin
      chk("a_rst_rvalid", {31'h0, rvalid_a}, 32'h0);
      chk("a_rst_rdata", rdata_a, 32'h0);
      last_a = 32'h0;
    end else if (rvalid_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_spurious_rvalid: got rvalid=1 expected no read outstanding (cycle %0d)", cyc);
      end else begin
        e = qa.pop_front();
        chk("a_rdata", rdata_a, e.d);
        chk("a_latency", 32'(cyc - e.c), 32'd1);
        last_a = e.d;
      end
    end else begin
      chk("a_hold", rdata_a, last_a);
    end
  end

  // Monitor B: same checks with a two-cycle read latency
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!resetn) begin
      chk("b_rst_rvalid", {31'h0, rvalid_b}, 32'h0);
      chk("b_rst_rdata", rdata_b, 32'h0);
      last_b = 32'h0;
    end else if (rvalid_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_spurious_rvalid: got rvalid=1 expected no read outstanding (cycle %0d)", cyc);
      end else begin
        e = qb.pop_front();
        chk("b_rdata", rdata_b, e.d);
        chk("b_latency", 32'(cyc - e.c), 32'd2);
        last_b = e.d;
      end
    end else begin
      chk("b_hold", rdata_b, last_b);
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem_a[i] = 32'h0;
    for (int i = 0; i < 300; i++) mem_b[i] = 32'h0;
    resetn = 1'b0; we = 1'b0; wbe = 4'h0; waddr = 9'h0; wdata = 32'h0; re = 1'b0; raddr = 9'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    idle(10);
    rd(5);
    idle(3);

    // Byte-enable merge at address 3: expected 0xAA22CC44
    wr(3, 32'hAABBCCDD, 4'hF);
    wr(3, 32'h11223344, 4'b0101);
    rd(3);
    idle(3);

    // Collision at address 7, then reread next cycle
    wr(7, 32'h12345678, 4'hF);
    idle(1);
    step(1'b1, 4'b0011, 7, 32'hFFFFFFFF, 1'b1, 7);
    rd(7);
    idle(3);

    // Streaming back-to-back reads of addr*3
    for (int i = 0; i < 16; i++) wr(i, 32'(i * 3), 4'hF);
    for (int i = 0; i < 16; i++) rd(i);
    idle(4);

    // Reset while reads are in flight; memory must survive
    rd(1);
    rd(2);
    do_reset();
    idle(4);
    rd(1);
    rd(2);
    idle(3);

    // Boundary accesses around DEPTH=300
    wr(299, 32'hCAFEF00D, 4'hF);
    rd(299);
    wr(400, 32'hDEADBEEF, 4'hF);
    rd(400);
    rd(0);
    rd(299);
    idle(3);

    // Randomized traffic concentrated on a few addresses to provoke collisions
    for (int n = 0; n < 1500; n++) begin
      int wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 4'($urandom), wa, $urandom, 1'($urandom_range(0, 1)), ra);
      end
    end

    idle(5);
    chk("a_drain", 32'(qa.size()), 32'h0);
    chk("b_drain", 32'(qb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
